// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator / capture pair.
//   CNT_W_DEFAULT : default counter and measurement width
//   cap_state_t   : capture state machine encoding
//   is_measuring  : true in the states where an edge is being timed
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } cap_state_t;

    function automatic logic is_measuring(input cap_state_t s);
        return (s == HIGH) || (s == LOW);
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// ---------------------------------------------------------------------------
// pwm_edge_sync
// Two-flop synchronizer for the asynchronous PWM pin followed by an edge
// register. Both strobes come from the same pair of flops, so rising and
// falling edges see identical delay and measured durations stay exact.
//   clk    in  : peripheral clock
//   rst    in  : asynchronous reset, active-high
//   pwm_in in  : raw pin input
//   level  out : synchronized input level
//   rise   out : single-cycle strobe on a synchronized 0->1 transition
//   fall   out : single-cycle strobe on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= pwm_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
    assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures period (rise to rise) and high time of an incoming PWM signal in
// clock cycles and publishes one measurement per complete period. Flags a
// stuck input when the cycle counter saturates while an edge is expected.
//   clk         in  : peripheral clock
//   rst         in  : asynchronous reset, active-high
//   pwm_in      in  : asynchronous PWM input from the pin
//   capture_en  in  : measurement enable
//   timeout_clr in  : single-cycle pulse clearing timeout
//   meas_period out : last complete period in cycles
//   meas_high   out : high time of that same period in cycles
//   meas_valid  out : single-cycle pulse when meas_period/meas_high update
//   timeout     out : sticky stuck-input flag
//   stuck_level out : synchronized input level when timeout was set
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             capture_en,
    input  logic             timeout_clr,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    logic level;
    logic rise;
    logic fall;

    pwm_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    cap_state_t       state_reg;
    cap_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] high_tmp_reg;
    logic [CNT_W-1:0] meas_period_reg;
    logic [CNT_W-1:0] meas_high_reg;
    logic             meas_valid_reg;
    logic             timeout_reg;
    logic             stuck_level_reg;

    logic cnt_max;
    logic take_high;
    logic take_period;
    logic set_timeout;

    // Saturated counter means the expected edge is overdue. Because the
    // timeout takes priority over a coincident edge, cnt+1 never wraps.
    assign cnt_max = &cnt_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!capture_en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = SYNC;
                SYNC: if (rise) state_next = HIGH;
                HIGH: begin
                    if (cnt_max)   state_next = SYNC;
                    else if (fall) state_next = LOW;
                end
                LOW: begin
                    if (cnt_max)   state_next = SYNC;
                    else if (rise) state_next = HIGH;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: strobes are acted on only in the state that expects them
    always_comb begin
        take_high   = 1'b0;
        take_period = 1'b0;
        set_timeout = 1'b0;
        if (capture_en) begin
            set_timeout = is_measuring(state_reg) && cnt_max;
            take_high   = (state_reg == HIGH) && !cnt_max && fall;
            take_period = (state_reg == LOW)  && !cnt_max && rise;
        end
    end

    // Cycle counter: cleared on every rise, saturating, parked at 0 in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            cnt_reg <= '0;
        end else if (rise) begin
            cnt_reg <= '0;
        end else if (!cnt_max) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Measurement registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_tmp_reg    <= '0;
            meas_period_reg <= '0;
            meas_high_reg   <= '0;
            meas_valid_reg  <= 1'b0;
        end else begin
            meas_valid_reg <= take_period;
            if (take_high) begin
                high_tmp_reg <= cnt_reg + 1'b1;
            end
            if (take_period) begin
                meas_period_reg <= cnt_reg + 1'b1;
                meas_high_reg   <= high_tmp_reg;
            end
        end
    end

    // Sticky timeout; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_reg     <= 1'b0;
            stuck_level_reg <= 1'b0;
        end else begin
            if (set_timeout) begin
                timeout_reg     <= 1'b1;
                stuck_level_reg <= level;
            end else if (timeout_clr) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign meas_period = meas_period_reg;
    assign meas_high   = meas_high_reg;
    assign meas_valid  = meas_valid_reg;
    assign timeout     = timeout_reg;
    assign stuck_level = stuck_level_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
// Drives pulse trains described as (high, low) cycle pairs. Every complete
// pulse that follows a synchronizing rise must be reported as
// period = high + low, high = high, at the rise that starts the next pulse.
// Expected reports go into a queue; a negedge monitor pops one per
// meas_valid and also checks report spacing equals the reported period.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic             capture_en;
    logic             timeout_clr;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             timeout;
    logic             stuck_level;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .capture_en  (capture_en),
        .timeout_clr (timeout_clr),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .meas_valid  (meas_valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int high;
        bit gap;
    } exp_t;

    exp_t sb[$];
    int   hs[$];
    int   ls[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Hold pwm_in at lvl for exactly n sampling edges
    task automatic drive(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the pulses queued in hs/ls; each is reported at the next rise
    task automatic run_pulses();
        exp_t e;
        for (int i = 0; i < hs.size(); i++) begin
            e.period = hs[i] + ls[i];
            e.high   = hs[i];
            e.gap    = (i > 0);
            sb.push_back(e);
            drive(1'b1, hs[i]);
            drive(1'b0, ls[i]);
        end
    endtask

    task automatic set_pulses(input int n, input int h, input int l);
        hs.delete();
        ls.delete();
        for (int i = 0; i < n; i++) begin
            hs.push_back(h);
            ls.push_back(l);
        end
    endtask

    task automatic start_capture();
        capture_en = 1'b1;
        drive(1'b0, 4);
    endtask

    task automatic stop_capture();
        drive(1'b1, 4);
        drive(1'b0, 6);
        capture_en = 1'b0;
        drive(1'b0, 3);
    endtask

    // Monitor
    int   mon_cyc  = 0;
    int   last_cyc = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        mon_cyc = mon_cyc + 1;
        if (!rst && meas_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got period %0d high %0d expected no report",
                         meas_period, meas_high);
            end else begin
                mon_e = sb.pop_front();
                chk("meas_period", int'(meas_period), mon_e.period);
                chk("meas_high", int'(meas_high), mon_e.high);
                if (mon_e.gap) chk("valid_spacing", mon_cyc - last_cyc, mon_e.period);
            end
            last_cyc = mon_cyc;
        end
    end

    initial begin
        bit seen;
        rst         = 1'b1;
        pwm_in      = 1'b0;
        capture_en  = 1'b0;
        timeout_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_meas_period", int'(meas_period), 0);
        chk("rst_meas_high", int'(meas_high), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_stuck_level", int'(stuck_level), 0);
        rst = 1'b0;
        drive(1'b0, 2);

        // 3 high / 5 low
        start_capture();
        set_pulses(5, 3, 5);
        run_pulses();
        stop_capture();

        // switch 3/5 -> 6/2 mid-stream
        start_capture();
        set_pulses(3, 3, 5);
        for (int i = 0; i < 3; i++) begin
            hs.push_back(6);
            ls.push_back(2);
        end
        run_pulses();
        stop_capture();

        // minimum pulse
        start_capture();
        set_pulses(5, 1, 1);
        run_pulses();
        stop_capture();

        // random pulse trains
        for (int s = 0; s < 3; s++) begin
            start_capture();
            hs.delete();
            ls.delete();
            for (int i = 0; i < 12; i++) begin
                hs.push_back(int'($urandom_range(1, 24)));
                ls.push_back(int'($urandom_range(1, 24)));
            end
            run_pulses();
            stop_capture();
        end

        // capture_en dropped mid-HIGH
        start_capture();
        set_pulses(3, 3, 5);
        run_pulses();
        drive(1'b1, 4);
        capture_en = 1'b0;
        drive(1'b1, 1);
        drive(1'b0, 5);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 5);
        end
        chk("hold_meas_period", int'(meas_period), 8);
        chk("hold_meas_high", int'(meas_high), 3);
        start_capture();
        set_pulses(4, 5, 7);
        run_pulses();
        stop_capture();

        // reset mid-LOW
        start_capture();
        set_pulses(3, 3, 5);
        run_pulses();
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("pre_rst_meas_period", int'(meas_period), 8);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_meas_period", int'(meas_period), 0);
        chk("async_rst_meas_high", int'(meas_high), 0);
        chk("async_rst_meas_valid", int'(meas_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 4);
        set_pulses(3, 4, 4);
        run_pulses();
        stop_capture();

        // stuck high: rise sampled at edge 1, synchronized strobe after edge 2,
        // counter 0 after edge 3, all-ones after edge 65538, flag registered
        // on edge 65539
        start_capture();
        set_pulses(2, 3, 5);
        run_pulses();
        pwm_in = 1'b1;
        seen   = 1'b0;
        for (int n = 1; n <= 70000; n++) begin
            @(posedge clk);
            #1;
            if (!seen && timeout) begin
                seen = 1'b1;
                chk("timeout_delay", n, 65539);
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_delay: got no timeout in 70000 cycles expected 65539");
        end
        chk("timeout_set", int'(timeout), 1);
        chk("stuck_level", int'(stuck_level), 1);
        chk("timeout_meas_period", int'(meas_period), 8);
        chk("timeout_meas_high", int'(meas_high), 3);
        timeout_clr = 1'b1;
        @(posedge clk);
        #1;
        timeout_clr = 1'b0;
        chk("timeout_clr", int'(timeout), 0);
        chk("stuck_level_kept", int'(stuck_level), 1);
        capture_en = 1'b0;
        drive(1'b0, 8);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
